// File: rtl/pipe_queue.sv
// rtl/pipe_queue.sv - circular pipeline queue with first-word-fall-through read port
// Optional statistics outputs are enabled by defining PIPE_QUEUE_STATS_EN.
module pipe_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int AF_TH  = DEPTH - 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SYS,
  input  logic              STALL_IN_UP,
  input  logic              STALL_IN_DN,
  input  logic [DATA_W-1:0] Data_IN,
  output logic [DATA_W-1:0] Data_OUT,
  output logic              STALL_OUT_UP,
  output logic              STALL_OUT_DN,
`ifdef PIPE_QUEUE_STATS_EN
  output logic [CNT_W-1:0]  COUNT_OUT,
  output logic [CNT_W-1:0]  HWM_OUT,
  output logic [15:0]       REFUSE_OUT,
`endif
  output logic              ALMOST_FULL_OUT
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Status flags come straight from the registered count so they never glitch with inputs
  always_comb begin
    w_full  = (r_cnt == CNT_W'(DEPTH));
    w_empty = (r_cnt == '0);
    // A full queue refuses the push even when a pop frees a slot this same edge
    w_push  = !STALL_IN_UP && !w_full && !SYS && !RESET;
    w_pop   = !STALL_IN_DN && !w_empty && !SYS && !RESET;
    w_cnt_nxt = r_cnt;
    if (SYS) begin
      w_cnt_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  assign STALL_OUT_UP    = w_full;
  assign STALL_OUT_DN    = w_empty;
  assign ALMOST_FULL_OUT = (r_cnt >= CNT_W'(AF_TH));
  assign Data_OUT        = r_mem[r_head];

  // Storage array: written at the tail on push, never reset
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_tail] <= Data_IN;
    end
  end

  // Pointers and occupancy; a flush rewinds everything and drops same-cycle traffic
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (SYS) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

`ifdef PIPE_QUEUE_STATS_EN
  logic [CNT_W-1:0] r_hwm;
  logic [15:0]      r_refuse;

  // High-water mark tracks the post-edge count so it never lags; flush leaves it alone
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hwm <= '0;
    end else if (w_cnt_nxt > r_hwm) begin
      r_hwm <= w_cnt_nxt;
    end
  end

  // Saturating count of cycles where upstream offered data but the queue was full
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_refuse <= '0;
    end else if (!STALL_IN_UP && w_full && (r_refuse != 16'hFFFF)) begin
      r_refuse <= r_refuse + 16'd1;
    end
  end

  assign COUNT_OUT  = r_cnt;
  assign HWM_OUT    = r_hwm;
  assign REFUSE_OUT = r_refuse;
`endif

endmodule

// File: doc/pipe_queue.md
PIPE_QUEUE -- requirements
Module: pipe_queue

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 64, meaning payload width in bits (instruction plus PC).
REQ-002 The block SHALL expose parameter DEPTH, default 8, meaning entry count; legal values are powers of two, 2 to 64.
REQ-003 The block SHALL expose parameter AF_TH, default DEPTH-2, meaning the occupancy at or above which ALMOST_FULL_OUT asserts; legal range is 1 to DEPTH.
REQ-004 The block SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SYS  in  1  synchronous flush request.
- STALL_IN_UP  in  1  high when upstream has no valid entry this cycle.
- STALL_IN_DN  in  1  high when downstream cannot accept this cycle.
- Data_IN  in  DATA_W  upstream payload.
- Data_OUT  out  DATA_W  head-of-queue payload.
- STALL_OUT_UP  out  1  high when the queue is full.
- STALL_OUT_DN  out  1  high when the queue is empty.
- ALMOST_FULL_OUT  out  1  high when occupancy >= AF_TH.
REQ-005 The block SHALL use one clock, CLK, with reset RESET asynchronous and active-high.

Function
REQ-006 The block SHALL hold occupancy cnt, width clog2(DEPTH+1), plus head and tail pointers of width clog2(DEPTH) that wrap modulo DEPTH.
REQ-007 Push SHALL occur on a rising edge when !STALL_IN_UP && !STALL_OUT_UP && !SYS: Data_IN is written at tail, tail increments, and cnt increments.
REQ-008 Pop SHALL occur on a rising edge when !STALL_IN_DN && !STALL_OUT_DN && !SYS: head increments and cnt decrements.
REQ-009 Simultaneous push and pop SHALL leave cnt unchanged and advance both pointers.
REQ-010 When full, push SHALL be refused even if a pop occurs in the same cycle; the space it frees is usable from the next cycle.
REQ-011 When empty, Data_IN SHALL NOT bypass to Data_OUT; push-to-visible latency is one cycle.
REQ-012 Data_OUT SHALL be a first-word-fall-through read of the head entry; its value when STALL_OUT_DN is high is don't-care.
REQ-013 STALL_OUT_UP SHALL equal (cnt == DEPTH), STALL_OUT_DN SHALL equal (cnt == 0), and ALMOST_FULL_OUT SHALL equal (cnt >= AF_TH), each decoded from registered cnt only.
REQ-014 SYS high on a rising edge SHALL set head, tail, and cnt to 0 and discard any same-cycle push or pop; storage contents need not be cleared.
REQ-015 Push, pop, and full or empty transitions SHALL be visible on the outputs in the cycle after the edge.

Reset
REQ-016 RESET high SHALL immediately force head=0, tail=0, and cnt=0, giving STALL_OUT_UP=0, STALL_OUT_DN=1, and ALMOST_FULL_OUT=0.
REQ-017 RESET asserted mid-operation SHALL abandon all entries; no push or pop SHALL complete while RESET is high.
REQ-018 Storage RAM SHALL NOT require reset.

Configuration
REQ-019 When macro PIPE_QUEUE_STATS_EN is defined, the block SHALL add output COUNT_OUT (width clog2(DEPTH+1), equal to cnt), output HWM_OUT (the highest cnt reached since reset; a flush does not clear it), and output REFUSE_OUT (16-bit saturating count of cycles with !STALL_IN_UP && STALL_OUT_UP). All three reset to 0.
REQ-020 When PIPE_QUEUE_STATS_EN is undefined, those ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification (DEPTH=4, AF_TH=2, DATA_W=64)
REQ-021 Release reset, then push 0xA, 0xB, 0xC, 0xD on consecutive cycles with STALL_IN_DN=1 -> STALL_OUT_DN falls after the first edge, ALMOST_FULL_OUT rises after the second, and STALL_OUT_UP rises after the fourth.
REQ-022 Full queue, fifth push of 0xE with a simultaneous pop -> 0xA leaves, 0xE is refused, cnt=3, and the next Data_OUT is 0xB.
REQ-023 Continuous push and pop for 10 cycles starting at cnt=1 -> cnt stays 1, pointers wrap past 3 to 0, and output order matches input order.
REQ-024 cnt=3 with SYS plus push 0xF in the same cycle -> cnt=0 and STALL_OUT_DN=1 next cycle, and 0xF never appears.
REQ-025 RESET pulsed asynchronously between edges at cnt=2 -> outputs reach their reset values before the next edge.
REQ-026 With PIPE_QUEUE_STATS_EN defined, fill to 4, hold pushing 3 cycles, then flush -> HWM_OUT=4, REFUSE_OUT=3, COUNT_OUT=0.
